// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling 8N1 UART receiver with a byte FIFO.
// Ports: i_clock/i_reset (sync, active-high), i_uart_rx serial input (idle
//   high), o_rx_data/o_rx_data_valid/i_rx_data_ready byte handshake,
//   o_framing_error and o_overrun 1-cycle pulses, o_busy while not IDLE.
module uart_rx_deserializer #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  input  logic       i_rx_data_ready,
  output logic       o_framing_error,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_M1     = SW'(M - 1);
  localparam logic [SW-1:0] S_M0     = SW'(M);
  localparam logic [SW-1:0] S_EVAL   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   F_FULL   = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    smp_q, smp_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick, maj, at_eval, at_wrap, push;

  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          full, empty, pop, wr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign tick    = (div_q == DIV_LAST);
  assign at_eval = tick && (s_q == S_EVAL);
  assign at_wrap = tick && (s_q == S_LAST);
  // Third vote is the live synced line at the evaluation tick.
  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & sync2_q) |
               (smp_q[1] & sync2_q);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    s_d     = s_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    if (tick) begin
      s_d = at_wrap ? '0 : s_q + SW'(1);
      if (s_q == S_M1) smp_d[0] = sync2_q;
      if (s_q == S_M0) smp_d[1] = sync2_q;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_START;
          div_d   = '0;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (at_eval && maj) begin
          state_d = ST_IDLE;
        end else if (at_wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_eval) shift_d = {maj, shift_q[7:1]};
        if (at_wrap) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so the next start edge is not missed.
        if (at_eval) begin
          if (maj) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q - rptr_q) == F_FULL);
  assign pop   = !empty && i_rx_data_ready;
  // A same-cycle pop frees the slot being written.
  assign wr    = push && (!full || pop);
  assign ovr_d = push && full && !pop;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      smp_q   <= 2'b11;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      if (wr)  wptr_q <= wptr_q + (AW+1)'(1);
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign o_rx_data_valid = !empty;
  assign o_rx_data       = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign o_framing_error = ferr_q;
  assign o_overrun       = ovr_q;
  assign o_busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed bench for uart_rx_deserializer.
// 64 clocks per bit; stimulus on negedge, outputs sampled at negedge+2.
module tb_uart_rx_deserializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] dout;
  logic       vld, fe, ov, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt, ov_cnt, vld_rise;
  logic       vld_prev = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] exp[$];
  bit         ok;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .CLOCK_FREQ(6400),
    .BAUD_RATE (100),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_uart_rx      (rx),
    .o_rx_data      (dout),
    .o_rx_data_valid(vld),
    .i_rx_data_ready(rdy),
    .o_framing_error(fe),
    .o_overrun      (ov),
    .o_busy         (busy)
  );

  always begin
    @(negedge clk);
    #2;
    if (vld && rdy) rxq.push_back(dout);
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if (vld && !vld_prev) vld_rise++;
    vld_prev = vld;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_mon();
    rxq.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    vld_rise = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (64) @(negedge clk);
    end
    rx = stop;
    repeat (64) @(negedge clk);
  endtask

  task automatic chk_q(input string nm);
    ok = (rxq.size() == exp.size());
    if (ok)
      foreach (exp[i]) if (rxq[i] !== exp[i]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %p want %p", nm, rxq, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    rdy = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    n_tests++;
    if ({vld, dout, fe, ov, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outs: got v=%b d=%h fe=%b ov=%b b=%b want 0",
               vld, dout, fe, ov, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    rdy = 1'b1;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    exp = '{8'h55, 8'hA3};
    chk_q("b2b_data");
    n_tests++;
    if (vld_rise !== 2) begin
      n_fail++;
      $display("FAIL b2b_valid: got %0d pulses want 2", vld_rise);
    end
    n_tests++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_err: got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b want 1", busy);
    end
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b0 || vld !== 1'b0 || rxq.size() != 0 || fe_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_idle: got b=%b v=%b n=%0d fe=%0d want 0 0 0 0",
               busy, vld, rxq.size(), fe_cnt);
    end
  endtask

  task automatic test_framing();
    clear_mon();
    rdy = 1'b1;
    send_byte(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    n_tests++;
    if (fe_cnt !== 1 || rxq.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err: got fe=%0d n=%0d b=%b want 1 0 1",
               fe_cnt, rxq.size(), busy);
    end
    rx = 1'b1;
    repeat (64) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_break: got busy=%b want 0", busy);
    end
    send_byte(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    exp = '{8'h0F};
    chk_q("frame_recover");
    n_tests++;
    if (fe_cnt !== 1 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL frame_cnt: got fe=%0d ov=%0d want 1 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    rdy = 1'b0;
    fork
      send_byte(8'h01, 1'b1);
      begin
        repeat (618) @(negedge clk);
        #2;
        n_tests++;
        if (vld !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_early: got v=%b want 0", vld);
        end
        @(negedge clk);
        #2;
        n_tests++;
        if (vld !== 1'b1 || dout !== 8'h01) begin
          n_fail++;
          $display("FAIL lat_visible: got v=%b d=%h want 1 01", vld, dout);
        end
      end
    join
    for (int b = 2; b <= 5; b++) send_byte(8'(b), 1'b1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (ov_cnt !== 1 || vld !== 1'b1 || dout !== 8'h01) begin
      n_fail++;
      $display("FAIL ovr_pulse: got ov=%0d v=%b d=%h want 1 1 01",
               ov_cnt, vld, dout);
    end
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_q("ovr_drain");
    n_tests++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_empty: got v=%b want 0", vld);
    end
  endtask

  task automatic test_full_pop();
    clear_mon();
    rdy = 1'b0;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
    fork
      send_byte(8'h05, 1'b1);
      begin
        repeat (618) @(negedge clk);
        rdy = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_q("fullpop_data");
    n_tests++;
    if (ov_cnt !== 0 || vld !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_ovr: got ov=%0d v=%b want 0 0", ov_cnt, vld);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h77;
    clear_mon();
    rdy = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (64) @(negedge clk);
    end
    rx = b[4];
    repeat (32) @(negedge clk);
    #2;
    n_tests++;
    if (vld !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got v=%b b=%b want 1 1", vld, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    #2;
    n_tests++;
    if (vld !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_post: got v=%b b=%b d=%h want 0 0 00",
               vld, busy, dout);
    end
    repeat (100) @(negedge clk);
    rdy = 1'b1;
    send_byte(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    exp = '{8'h81};
    chk_q("rmid_recv");
    n_tests++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL rmid_err: got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
